// File: rtl/sqrt_arb_pkg.sv
// Shared types and default widths for the sqrt round-robin scheduler.
package sqrt_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ROOT_W  = DEF_DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first set request at or after ptr, wrapping.
module rr_pick
    import sqrt_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        // Farthest offset first, so the requester nearest to ptr overwrites and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (|(req & (NUM_REQ'(1) << pos))) begin
                grant = NUM_REQ'(1) << pos;
                idx   = ID_W'(pos);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one sequential sqrt unit among NUM_REQ requesters, one operation in flight,
// returning each root tagged with the owning requester index.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROOT_W  = DEF_ROOT_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [ROOT_W-1:0]         rsp_root,
    input  logic                      rsp_ready,
    output logic                      sq_start,
    output logic [DATA_W-1:0]         sq_data_in,
    input  logic [ROOT_W-1:0]         sq_data_out,
    input  logic                      sq_done,
    output logic                      busy
);

    state_t                           state;
    state_t                           state_nxt;
    logic [ID_W-1:0]                  rr_ptr;
    logic [ID_W-1:0]                  op_id;
    logic [DATA_W-1:0]                op_data;
    logic [ROOT_W-1:0]                root_q;
    logic [NUM_REQ-1:0]               pick_grant;
    logic [ID_W-1:0]                  pick_idx;
    logic                             pick_any;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_arr;
    logic                             take;

    assign req_arr = req_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_grant;
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (sq_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, tag and result registers; done pulses outside WAIT never reach root_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            op_data <= '0;
            op_id   <= '0;
            root_q  <= '0;
        end else begin
            if (take) begin
                op_data <= req_arr[pick_idx];
                op_id   <= pick_idx;
                rr_ptr  <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
            end
            if (state == WAIT && sq_done) begin
                root_q <= sq_data_out;
            end
        end
    end

    assign sq_start   = (state == ISSUE);
    assign sq_data_in = op_data;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = op_id;
    assign rsp_root   = root_q;
    assign busy       = (state != IDLE);

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin scheduler that shares the single sequential `sqrt` unit among several requesters, e.g. per-lane ray/sphere discriminant stages. It accepts one radicand at a time over a valid/ready handshake, drives the sqrt unit's `start`/`done` protocol, and returns the root tagged with the requester index. Exactly one operation is in flight at a time.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 16: radicand width; must match the sqrt unit.
- `ROOT_W`, default 8: root width, equal to `DATA_W/2`.
- `ID_W`, default `$clog2(NUM_REQ)`: tag width.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_data` in NUM_REQ*DATA_W: packed radicands; requester i occupies slice [i*DATA_W +: DATA_W].
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `rsp_valid` out 1: result available.
- `rsp_id` out ID_W: index of the requester that owns the result.
- `rsp_root` out ROOT_W: integer square root.
- `rsp_ready` in 1: consumer accepts the result.
- `sq_start` out 1: to sqrt `start`.
- `sq_data_in` out DATA_W: to sqrt `data_in`.
- `sq_data_out` in ROOT_W: from sqrt `data_out`.
- `sq_done` in 1: from sqrt `done`, a one-cycle pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, pick a grant `g` round-robin, starting the search at `rr_ptr`.
  - Assert `req_ready[g]` combinationally in this cycle only.
  - Latch `req_data[g]` into `op_data` and `g` into `op_id`.
  - Set `rr_ptr <= (g+1) mod NUM_REQ`, then go to ISSUE.
  - With no request pending, stay in IDLE.
- **ISSUE**
  - Assert `sq_start` for exactly one cycle, with `sq_data_in = op_data`, then go to WAIT.
  - `sq_data_in` holds `op_data` in every state.
- **WAIT**
  - On `sq_done`, capture `sq_data_out` into `rsp_root` and go to RESP.
  - The block makes no assumption on sqrt latency; nominally `sq_done` arrives about 10 cycles after `sq_start`.
- **RESP**
  - `rsp_valid=1`. `rsp_id=op_id` and `rsp_root` are held stable.
  - When `rsp_valid && rsp_ready`, go to IDLE. The next grant is possible on the following cycle.
- **Arbitration and handshake rules**
  - `req_ready` is never asserted outside IDLE.
  - A requester whose `req_valid` drops before its grant is simply skipped.
  - `sq_done` in any state other than WAIT is ignored; the response is not corrupted.
- **Reset** (`rst=1` at a clock edge):
  - state=IDLE, `rr_ptr=0`, `op_data=0`, `op_id=0`, `rsp_root=0`.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_root`, `sq_start`, `sq_data_in`, `busy`.
  - At integration, sqrt `rst_n` is tied to `~rst`, so a reset mid-operation aborts both blocks together. An in-flight result is dropped, and the requester is not re-served unless it re-requests.
- **Arithmetic**: no arithmetic beyond the pointer increment. `rr_ptr` wraps from NUM_REQ-1 to 0.

## Timing
- Grant at cycle T. `sq_start` at T+1. `sq_done` at T+1+L, where L is the sqrt latency. `rsp_valid` from T+2+L.
- Earliest next grant is the cycle after the response handshake.
- Peak throughput is one result per L+3 cycles.
- Grant-to-`rsp_valid` latency is L+2 with no backpressure.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.
- `busy` goes high the cycle after a grant. It returns low the cycle after the RESP handshake.

## Structure
- Package `sqrt_arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), default widths.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are the request vector and `rr_ptr`; outputs are the one-hot grant, the encoded index and `any`.
- The top level holds the FSM, op registers and the response register.
- The bench instantiates `sqrt_arbiter` together with the real sqrt unit.

## Test plan
1. Single request: requester 2, data 144 → `req_ready=4'b0100` for one cycle, then `sq_start` one cycle later, then `rsp_valid` with `rsp_id=2`, `rsp_root=12`.
2. All four request simultaneously after reset (data 1, 4, 9, 16) → served in order 0, 1, 2, 3 with roots 1, 2, 3, 4.
3. Requester 0 requests continuously, requester 3 requests once → requester 3 is served no later than the second grant after its `req_valid` rises.
4. Backpressure: hold `rsp_ready` low for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_root` stay stable; no `req_ready` and no `sq_start` during the stall.
5. Boundaries: data 0 → 0, 15 → 3, 16'hFFFF → 255; `rr_ptr` wraps after requester 3 is granted.
6. Assert `rst` for one cycle in WAIT → all outputs are 0 the next cycle; a fresh request to requester 1 then completes normally, with no stale `rsp_valid` from the aborted operation.
